// File: rtl/multicycle_control.sv
// multicycle_control: main FSM and ALU decoder for the multicycle RV32I-subset core.
// Ports: clk, rst_n (async active-low); op/funct3/funct7b5 from the instruction register;
// zero from the ALU. Outputs: pc_write, adr_src, mem_write, ir_write, reg_write,
// result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal.
module multicycle_control #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, ILLEGAL
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;
  state_t state_q, state_d;
  logic [1:0] alu_op;
  logic pc_update, branch, ill_state, mw, iw, rw, funct_bad;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    adr_src = 1'b0;
    mw = 1'b0;
    iw = 1'b0;
    rw = 1'b0;
    result_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    pc_update = 1'b0;
    branch = 1'b0;
    ill_state = 1'b0;
    case (state_q)
      FETCH: begin
        iw = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
        pc_update = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d = (op == OP_LW || op == OP_SW) ? MEMADR :
                  op == OP_R   ? EXECUTER :
                  op == OP_I   ? EXECUTEI :
                  op == OP_JAL ? JAL :
                  op == OP_BEQ ? BEQ :
                  ILLEGAL_TRAP ? ILLEGAL : FETCH;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d = op == OP_LW ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        rw = 1'b1;
        state_d = FETCH;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mw = 1'b1;
        state_d = FETCH;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op = 2'b10;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        rw = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d = ALUWB;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op = 2'b01;
        branch = 1'b1;
        state_d = FETCH;
      end
      ILLEGAL: ill_state = 1'b1;
      default: state_d = FETCH;
    endcase
  end
  // op[5] separates R-type from op-imm so addi with instr[30] set stays an add
  assign funct_bad = alu_op == 2'b10 && !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
  assign alu_control = alu_op == 2'b00 ? 3'b000 :
                       alu_op == 2'b01 ? 3'b001 :
                       funct3 == 3'b000 ? {2'b00, op[5] & funct7b5} :
                       funct3 == 3'b010 ? 3'b101 :
                       funct3 == 3'b110 ? 3'b011 :
                       funct3 == 3'b111 ? 3'b010 : 3'b000;
  assign imm_src = op == OP_SW ? 2'b01 : op == OP_BEQ ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
  // strobes are gated by rst_n because the reset state FETCH would otherwise assert them
  assign pc_write = rst_n & (pc_update | (branch & zero));
  assign ir_write = rst_n & iw;
  assign reg_write = rst_n & rw;
  assign mem_write = rst_n & mw;
  assign illegal = ill_state | funct_bad;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multicycle control FSM, trap and nop variants.
module tb_multicycle_control;
  logic clk = 1'b0, rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, zero;
  logic pcw_t, adr_t, mw_t, iw_t, rw_t, ill_t, pcw_n, adr_n, mw_n, iw_n, rw_n, ill_n;
  logic [1:0] rs_t, a_t, b_t, imm_t, rs_n, a_n, b_n, imm_n;
  logic [2:0] alu_t, alu_n;
  logic [16:0] obs_t, obs_n;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  multicycle_control #(.ILLEGAL_TRAP(1'b1)) u_trap (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pcw_t), .adr_src(adr_t), .mem_write(mw_t), .ir_write(iw_t), .reg_write(rw_t),
    .result_src(rs_t), .alu_src_a(a_t), .alu_src_b(b_t), .imm_src(imm_t),
    .alu_control(alu_t), .illegal(ill_t));
  multicycle_control #(.ILLEGAL_TRAP(1'b0)) u_nop (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pcw_n), .adr_src(adr_n), .mem_write(mw_n), .ir_write(iw_n), .reg_write(rw_n),
    .result_src(rs_n), .alu_src_a(a_n), .alu_src_b(b_n), .imm_src(imm_n),
    .alu_control(alu_n), .illegal(ill_n));
  assign obs_t = {pcw_t, adr_t, mw_t, iw_t, rw_t, rs_t, a_t, b_t, imm_t, alu_t, ill_t};
  assign obs_n = {pcw_n, adr_n, mw_n, iw_n, rw_n, rs_n, a_n, b_n, imm_n, alu_n, ill_n};
  function automatic logic [16:0] e(input logic pcw, adr, mw, iw, rw,
      input logic [1:0] rs, a, b, imm, input logic [2:0] alu, input logic ill);
    return {pcw, adr, mw, iw, rw, rs, a, b, imm, alu, ill};
  endfunction
  function automatic logic [16:0] fetch_v(input logic [1:0] imm);
    return e(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
  endfunction
  function automatic logic [16:0] dec_v(input logic [1:0] imm);
    return e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
  endfunction
  function automatic logic [16:0] rst_v(input logic [1:0] imm);
    return e(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
  endfunction
  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    zero = z;
    #1;
  endtask
  logic [2:0] r_f3 [6] = '{3'b000, 3'b000, 3'b010, 3'b111, 3'b110, 3'b001};
  logic r_f7 [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [2:0] r_alu [6] = '{3'b001, 3'b000, 3'b101, 3'b010, 3'b011, 3'b000};
  logic r_ill [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  initial begin
    rst_n = 1'b0;
    op = 7'b0000011;
    funct3 = 3'b000;
    funct7b5 = 1'b0;
    zero = 1'b0;
    #3 chk("reset", obs_t, rst_v(2'b00));
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("lw_fetch", obs_t, fetch_v(2'b00));
    step(); chk("lw_decode", obs_t, dec_v(2'b00));
    step(); chk("lw_memadr", obs_t, e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
    step(); chk("lw_memread", obs_t, e(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    step(); chk("lw_memwb", obs_t, e(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    step();
    for (int i = 0; i < 6; i++) begin
      set_in(7'b0110011, r_f3[i], r_f7[i], 1'b0);
      chk($sformatf("r%0d_fetch", i), obs_t, fetch_v(2'b00));
      step(); chk($sformatf("r%0d_decode", i), obs_t, dec_v(2'b00));
      step(); chk($sformatf("r%0d_exec", i), obs_t,
                  e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, r_alu[i], r_ill[i]));
      step(); chk($sformatf("r%0d_aluwb", i), obs_t,
                  e(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      step();
    end
    set_in(7'b0010011, 3'b000, 1'b1, 1'b0);
    chk("addi_fetch", obs_t, fetch_v(2'b00));
    step(); step(); chk("addi_exec", obs_t, e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
    step(); chk("addi_aluwb", obs_t, e(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    step();
    for (int z = 1; z >= 0; z--) begin
      set_in(7'b1100011, 3'b000, 1'b0, z[0]);
      chk($sformatf("beq%0d_fetch", z), obs_t, fetch_v(2'b10));
      step(); chk($sformatf("beq%0d_decode", z), obs_t, dec_v(2'b10));
      step(); chk($sformatf("beq%0d_beq", z), obs_t,
                  e(z[0], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
      step(); chk($sformatf("beq%0d_next_fetch", z), obs_t, fetch_v(2'b10));
    end
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    chk("sw_fetch", obs_t, fetch_v(2'b01));
    step(); chk("sw_decode", obs_t, dec_v(2'b01));
    step(); chk("sw_memadr", obs_t, e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
    step(); chk("sw_memwrite", obs_t, e(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
    step(); chk("sw_next_fetch", obs_t, fetch_v(2'b01));
    set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
    step(); chk("jal_decode", obs_t, dec_v(2'b11));
    step(); chk("jal_jal", obs_t, e(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
    step(); chk("jal_aluwb", obs_t, e(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0));
    step(); chk("jal_next_fetch", obs_t, fetch_v(2'b11));
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    step(); step(); step(); chk("sw2_memwrite", obs_t, e(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
    #2 rst_n = 1'b0;
    #1 chk("midrst_now", obs_t, rst_v(2'b01));
    step(); chk("midrst_held", obs_t, rst_v(2'b01));
    #2 rst_n = 1'b1;
    #1 chk("midrst_release_fetch", obs_t, fetch_v(2'b01));
    step(); chk("midrst_decode", obs_t, dec_v(2'b01));
    step(); step(); chk("midrst_memwrite", obs_t, e(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
    step();
    set_in(7'b1111111, 3'b000, 1'b0, 1'b0);
    chk("ill_fetch", obs_t, fetch_v(2'b00));
    step(); chk("ill_decode", obs_t, dec_v(2'b00));
    step(); chk("nop_refetch", obs_n, fetch_v(2'b00));
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("ill_park%0d", i), obs_t, e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1));
      chk($sformatf("nop_illegal%0d", i), {16'b0, ill_n}, 17'b0);
      step();
    end
    #2 rst_n = 1'b0;
    #1 chk("ill_reset", obs_t, rst_v(2'b00));
    #2 rst_n = 1'b1;
    #1 chk("ill_recover_fetch", obs_t, fetch_v(2'b00));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
